trig_capture_queue: RTL and testbench

- Parametrised successor to the per-channel capture RAM.
- Adds a circular write pointer, a pre/post-trigger capture state machine and an ordered oldest-to-newest dump port, all in one block with its own storage.
- One instance sits per scope channel, between the sample decimator and the UART/command dump logic.
- Storage is an inferred 1R1W synchronous RAM with 1-cycle read latency.

---
 rtl/trig_capture_queue.sv | 130 +++++++++++++
 tb/tb_trig_capture_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture_queue.sv
// trig_capture_queue: circular pre/post-trigger capture buffer with ordered oldest-to-newest dump
module trig_capture_queue #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic [LOG2-1:0]  trig_pos,
    input  logic             smpl_vld,
    input  logic [WIDTH-1:0] smpl,
    input  logic             trigger,
    input  logic             rd_start,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic             rd_last,
    output logic             armed,
    output logic             capture_done,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE, DUMP} state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   DCNT = (LOG2 + 1)'(ENTRIES);

    state_t            state_q, state_d;
    logic [LOG2-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
    logic [LOG2-1:0]   fill_q, fill_d, post_q, post_d, tp_q, tp_d;
    logic [LOG2:0]     dcnt_q, dcnt_d;
    logic [LOG2-1:0]   tp_in, pre;
    logic              accept, trig, issue;
    logic [WIDTH-1:0]  mem [ENTRIES];

    function automatic logic [LOG2-1:0] inc(input logic [LOG2-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign tp_in  = (trig_pos > LAST) ? LAST : trig_pos;
    assign pre    = LAST - tp_q;
    assign accept = smpl_vld && !arm && (state_q inside {FILL, ARMED, POST});
    assign trig   = accept && trigger && (state_q == ARMED);
    assign issue  = (state_q == DUMP) && (dcnt_q != DCNT);

    // next-state: arm restarts from any non-dump state and outranks trigger
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        fill_d  = fill_q;
        post_d  = post_q;
        tp_d    = tp_q;
        dcnt_d  = dcnt_q;
        if (accept)
            waddr_d = inc(waddr_q);
        if (arm && state_q != DUMP) begin
            tp_d    = tp_in;
            state_d = (tp_in == LAST) ? ARMED : FILL;
            waddr_d = '0;
            fill_d  = '0;
            post_d  = '0;
        end else begin
            case (state_q)
                FILL: if (accept) begin
                    fill_d  = fill_q + 1'b1;
                    state_d = (fill_q + 1'b1 == pre) ? ARMED : FILL;
                end
                ARMED: if (trig) begin
                    post_d  = tp_q;
                    state_d = (tp_q == '0) ? DONE : POST;
                end
                POST: if (accept) begin
                    post_d  = post_q - 1'b1;
                    state_d = (post_q == LOG2'(1)) ? DONE : POST;
                end
                DONE: if (rd_start) begin
                    state_d = DUMP;
                    raddr_d = waddr_q;
                    dcnt_d  = '0;
                end
                DUMP: begin
                    raddr_d = issue ? inc(raddr_q) : raddr_q;
                    dcnt_d  = issue ? dcnt_q + 1'b1 : dcnt_q;
                    state_d = issue ? DUMP : DONE;
                end
                default: ;
            endcase
        end
    end

    // state, pointers and registered status/dump outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            raddr_q      <= '0;
            fill_q       <= '0;
            post_q       <= '0;
            tp_q         <= '0;
            dcnt_q       <= '0;
            rd_data      <= '0;
            rd_vld       <= 1'b0;
            rd_last      <= 1'b0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            fill_q       <= fill_d;
            post_q       <= post_d;
            tp_q         <= tp_d;
            dcnt_q       <= dcnt_d;
            rd_vld       <= issue;
            rd_last      <= issue && (dcnt_q == DCNT - 1'b1);
            armed        <= state_d == ARMED;
            capture_done <= state_d == DONE;
            busy         <= state_d inside {FILL, ARMED, POST, DUMP};
            if (issue)
                rd_data <= mem[raddr_q];
        end
    end

    // sample storage, written at the circular pointer
    always_ff @(posedge clk) begin
        if (accept)
            mem[waddr_q] <= smpl;
    end
endmodule

// File: tb/tb_trig_capture_queue.sv
// tb_trig_capture_queue: 8-entry and 384-entry instances driven in lockstep, checked against a sample-history model
module tb_trig_capture_queue;
    localparam int P_IDLE = 0, P_FILL = 1, P_ARMED = 2, P_POST = 3, P_DONE = 4, P_DUMP = 5;

    logic       clk = 0, rst_n = 0, arm = 0, smpl_vld = 0, trigger = 0, rd_start = 0;
    logic [8:0] trig_pos = 0;
    logic [7:0] smpl = 0;
    logic       vld [2], lst [2], armd [2], dn [2], bsy [2];
    logic [7:0] rdat [2];

    int vectors = 0, errors = 0;
    int ph [2], cnt [2], pc [2], tpm [2], dleft [2], run [2];
    logic [7:0] hist [2][$];
    logic [8:0] sb [2][$];

    always #5 clk = ~clk;

    trig_capture_queue #(.WIDTH(8), .ENTRIES(8), .LOG2(4)) u_a (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_pos(trig_pos[3:0]), .smpl_vld(smpl_vld),
        .smpl(smpl), .trigger(trigger), .rd_start(rd_start), .rd_data(rdat[0]), .rd_vld(vld[0]),
        .rd_last(lst[0]), .armed(armd[0]), .capture_done(dn[0]), .busy(bsy[0]));

    trig_capture_queue u_b (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_pos(trig_pos), .smpl_vld(smpl_vld),
        .smpl(smpl), .trigger(trigger), .rd_start(rd_start), .rd_data(rdat[1]), .rd_vld(vld[1]),
        .rd_last(lst[1]), .armed(armd[1]), .capture_done(dn[1]), .busy(bsy[1]));

    function automatic int n(input int k);
        return k ? 384 : 8;
    endfunction

    task automatic check(input string name, input int k, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d]: got %0d, expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = P_IDLE;
            hist[k].delete();
            sb[k].delete();
        end
    endtask

    // behaviour at the coming edge: the buffer is simply the newest ENTRIES samples since arm
    task automatic model_step(input int k);
        int nn, t;
        nn = n(k);
        if (ph[k] == P_DUMP) begin
            dleft[k]--;
            if (dleft[k] == 0) ph[k] = P_DONE;
        end else if (arm) begin
            t = int'(trig_pos) & (k ? 511 : 15);
            tpm[k] = (t > nn - 1) ? nn - 1 : t;
            hist[k].delete();
            cnt[k] = 0;
            ph[k] = (tpm[k] == nn - 1) ? P_ARMED : P_FILL;
        end else if (smpl_vld && ph[k] >= P_FILL && ph[k] <= P_POST) begin
            hist[k].push_back(smpl);
            if (hist[k].size() > nn) void'(hist[k].pop_front());
            if (ph[k] == P_FILL) begin
                cnt[k]++;
                if (cnt[k] == nn - 1 - tpm[k]) ph[k] = P_ARMED;
            end else if (ph[k] == P_ARMED) begin
                if (trigger) begin
                    pc[k] = tpm[k];
                    ph[k] = (tpm[k] == 0) ? P_DONE : P_POST;
                end
            end else begin
                pc[k]--;
                if (pc[k] == 0) ph[k] = P_DONE;
            end
        end else if (ph[k] == P_DONE && rd_start) begin
            ph[k] = P_DUMP;
            dleft[k] = nn + 1;
            for (int i = 0; i < hist[k].size(); i++)
                sb[k].push_back({i == hist[k].size() - 1, hist[k][i]});
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check("armed", k, armd[k], ph[k] == P_ARMED);
            check("capture_done", k, dn[k], ph[k] == P_DONE);
            check("busy", k, bsy[k], ph[k] == P_FILL || ph[k] == P_ARMED || ph[k] == P_POST || ph[k] == P_DUMP);
        end
    endtask

    task automatic tick(input bit a, input int t, input bit v, input int s, input bit tr, input bit rs);
        arm = a; trig_pos = 9'(t); smpl_vld = v; smpl = 8'(s); trigger = tr; rd_start = rs;
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic samp(input int s, input bit tr);
        tick(0, 0, 1, s, tr, 0);
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic dump8();
        tick(0, 0, 0, 0, 0, 1);
        idle(11);
    endtask

    // monitor: pops the scoreboard on every rd_vld and checks dump length
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) run[k] = 0;
            else if (vld[k]) begin
                run[k]++;
                if (sb[k].size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL rd_vld[inst %0d]: got 1, expected 0 (no dump pending) at %0t", k, $time);
                end else begin
                    logic [8:0] e;
                    e = sb[k].pop_front();
                    check("rd_data", k, rdat[k], e[7:0]);
                    check("rd_last", k, lst[k], e[8]);
                end
            end else if (run[k] != 0) begin
                check("dump_len", k, run[k], n(k));
                run[k] = 0;
            end
        end
    end

    initial begin
        run[0] = 0; run[1] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_rd_vld", k, vld[k], 0);
            check("reset_rd_data", k, rdat[k], 0);
        end
        check_outputs();
        rst_n = 1;
        idle(2);
        // basic capture
        tick(1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) samp(i, i == 9);
        samp(50, 1);
        dump8();
        dump8();
        // early triggers in FILL are ignored
        tick(1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) samp(i, i == 1 || i == 3 || i == 12);
        dump8();
        // trig_pos extremes and clamp
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) samp(i, i == 7);
        dump8();
        tick(1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) samp(100 + i, i == 0);
        dump8();
        tick(1, 9, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) samp(200 + i, i == 0);
        dump8();
        // re-arm mid-POST, rd_start in POST, arm with trigger
        tick(1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) samp(i, i == 4);
        tick(0, 0, 1, 5, 0, 1);
        tick(1, 3, 0, 0, 0, 0);
        for (int i = 10; i < 14; i++) samp(i, 0);
        tick(1, 3, 1, 14, 1, 0);
        for (int i = 20; i < 31; i++) samp(i, i == 26);
        dump8();
        // reset on dump cycle 3
        tick(0, 0, 0, 0, 0, 1);
        idle(3);
        rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("abort_rd_vld", k, vld[k], 0);
            check("abort_busy", k, bsy[k], 0);
            check("abort_done", k, dn[k], 0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) tick(0, 0, 1, i, 1, i == 2);
        // non-power-of-two depth ramp
        tick(1, 100, 0, 0, 0, 0);
        for (int i = 0; i < 1000; i++) samp(i, i == 699);
        tick(0, 0, 0, 0, 0, 1);
        idle(400);
        // randomised traffic
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 99) < 3, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 15),
                 $urandom_range(0, 99) < 70, $urandom_range(0, 255), $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 8);
        tick(1, 0, 0, 0, 0, 0);
        idle(400);
        for (int k = 0; k < 2; k++) check("sb_drained", k, sb[k].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
